// File: rtl/prog_ctrl_pkg.sv
// Shared types and constants for the program run controller.
package prog_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, DRAIN, DONE} run_state_t;

  localparam int unsigned BASE_W = 10;
  localparam logic [BASE_W-1:0] PC_BASE [3] = '{10'd0, 10'd256, 10'd512};
  localparam logic [1:0] PROG_SEL_ILLEGAL = 2'd3;

  // Table lookup that never indexes past the three legal programs.
  function automatic logic [BASE_W-1:0] pc_base_of(input logic [1:0] sel);
    logic [BASE_W-1:0] base;
    base = PC_BASE[0];
    case (sel)
      2'd1:    base = PC_BASE[1];
      2'd2:    base = PC_BASE[2];
      default: base = PC_BASE[0];
    endcase
    return base;
  endfunction

endpackage

// File: rtl/prog_run_ctrl_if.sv
// Data-memory request bus; the requester is master, the memory side is slave.
interface prog_run_ctrl_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
);
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  modport master (output we, addr, wdata, input rdata);
  modport slave  (input we, addr, wdata, output rdata);
endinterface

// File: rtl/dmem_port_mux.sv
// Combinational owner select for the single data-memory port.
module dmem_port_mux (
  input  logic             host_gnt,
  prog_run_ctrl_if.slave   host,
  prog_run_ctrl_if.slave   core,
  prog_run_ctrl_if.master  mem
);

  // The non-owner's write enable is simply dropped.
  assign mem.we    = host_gnt ? host.we    : core.we;
  assign mem.addr  = host_gnt ? host.addr  : core.addr;
  assign mem.wdata = host_gnt ? host.wdata : core.wdata;

  assign host.rdata = mem.rdata;
  assign core.rdata = mem.rdata;

endmodule

// File: rtl/prog_run_ctrl.sv
// Run controller: launches a core program, watchdogs it, and owns the data-memory port.
// Optional: define PRG_CYCLE_CNT_EN to add the cyc_cnt run-length output.
module prog_run_ctrl
  import prog_ctrl_pkg::*;
#(
  parameter int unsigned AW     = 8,
  parameter int unsigned DW     = 8,
  parameter int unsigned PCW    = 10,
  parameter int unsigned WDOG_W = 16
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              req,
  input  logic [1:0]        prog_sel,
  output logic              done,
  output logic              timeout,
  output logic              sel_err,
  output logic              busy,
  output logic              core_start,
  output logic [PCW-1:0]    core_pc_base,
  input  logic              core_halt,
  output logic              host_gnt,
`ifdef PRG_CYCLE_CNT_EN
  output logic [WDOG_W-1:0] cyc_cnt,
`endif
  prog_run_ctrl_if.slave    host,
  prog_run_ctrl_if.slave    core,
  prog_run_ctrl_if.master   mem
);

  run_state_t        state, nxt_state;
  logic [WDOG_W-1:0] wdog, nxt_wdog;
  logic              nxt_done, nxt_timeout, nxt_sel_err;
  logic [PCW-1:0]    nxt_pc_base;
  logic              nxt_busy_c;

  // Next state and next values of every registered output.
  always_comb begin
    nxt_state   = state;
    nxt_wdog    = wdog;
    nxt_done    = done;
    nxt_timeout = timeout;
    nxt_sel_err = 1'b0;
    nxt_pc_base = core_pc_base;
    unique case (state)
      IDLE, DONE: begin
        if (req) begin
          if (prog_sel == PROG_SEL_ILLEGAL) begin
            nxt_sel_err = 1'b1;
          end else begin
            nxt_pc_base = PCW'(pc_base_of(prog_sel));
            nxt_done    = 1'b0;
            nxt_timeout = 1'b0;
            nxt_state   = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        nxt_wdog  = '0;
        nxt_state = RUN;
      end
      RUN: begin
        // wdog==0 marks the first RUN cycle, where a stale halt is ignored.
        if (core_halt && (wdog != '0)) begin
          nxt_state = DRAIN;
        end else if (&wdog) begin
          nxt_state   = DONE;
          nxt_done    = 1'b1;
          nxt_timeout = 1'b1;
        end else begin
          nxt_wdog = wdog + WDOG_W'(1);
        end
      end
      DRAIN: begin
        nxt_state = DONE;
        nxt_done  = 1'b1;
      end
      default: nxt_state = IDLE;
    endcase
  end

  assign nxt_busy_c = (nxt_state == LAUNCH) || (nxt_state == RUN) || (nxt_state == DRAIN);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state        <= IDLE;
      wdog         <= '0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      sel_err      <= 1'b0;
      busy         <= 1'b0;
      host_gnt     <= 1'b1;
      core_start   <= 1'b0;
      core_pc_base <= '0;
    end else begin
      state        <= nxt_state;
      wdog         <= nxt_wdog;
      done         <= nxt_done;
      timeout      <= nxt_timeout;
      sel_err      <= nxt_sel_err;
      busy         <= nxt_busy_c;
      host_gnt     <= !nxt_busy_c;
      core_start   <= (nxt_state == LAUNCH);
      core_pc_base <= nxt_pc_base;
    end
  end

`ifdef PRG_CYCLE_CNT_EN
  // Run length captured on entry to DONE, cleared by the next launch.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      cyc_cnt <= '0;
    end else if (nxt_state == LAUNCH) begin
      cyc_cnt <= '0;
    end else if ((nxt_state == DONE) && (state != DONE)) begin
      cyc_cnt <= wdog;
    end
  end
`endif

  dmem_port_mux u_mux (
    .host_gnt (host_gnt),
    .host     (host),
    .core     (core),
    .mem      (mem)
  );

endmodule
